dmem_responder: RTL and testbench

- Data-memory responder (slave) for the core's load/store memory port.
- Sits on the far end of the mem_addr / mem_we / mem_req / mem_wdata / mem_rdata / mem_err interface driven by the load/store ALU.
- Contains a word-organised single-port RAM with byte-enable writes, address range and alignment checking, and a response FSM matched to the initiator's fixed two-cycle request window.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder: byte-enable word RAM behind a two-cycle request window.
// Optional saturating access counters are built when DMEM_STATS_EN is defined.
module dmem_responder #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic              mem_we,
    input  logic              mem_req,
    input  logic [XLEN/8-1:0] mem_be,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN-1:0]   mem_rdata,
    output logic              mem_err,
    output logic [31:0]       stat_rd,
    output logic [31:0]       stat_wr,
    output logic [31:0]       stat_err
);
    localparam int            AW     = $clog2(DEPTH);
    localparam int            NB     = XLEN / 8;
    localparam logic [XLEN:0] BASE_X = {1'b0, BASE_ADDR};
    localparam logic [XLEN:0] SPAN_X = (XLEN + 1)'(DEPTH) << 2;

    typedef enum logic [1:0] {IDLE, RESP, TAIL} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] ram [DEPTH];
    logic [XLEN:0]   diff;
    logic [AW-1:0]   idx;
    logic            req_err;
    logic            capture;
    logic            wr_en;

    // The extra top bit of diff is the borrow, so below-base and past-end need no overflowing add.
    always_comb begin
        diff    = {1'b0, mem_addr} - BASE_X;
        idx     = diff[AW+1:2];
        req_err = (mem_addr[1:0] != 2'b00) || diff[XLEN] || (diff >= SPAN_X);
        capture = (state_q == IDLE) && mem_req;
        wr_en   = capture && mem_we && !req_err && rst_n;
    end

    always_comb begin
        state_d = state_q;
        rdata_d = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = RESP;
                    err_d   = req_err;
                    if (!mem_we && !req_err) begin
                        rdata_d = ram[idx];
                    end
                end
            end
            RESP:    state_d = mem_req ? TAIL : IDLE;
            TAIL:    state_d = mem_req ? TAIL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_be[i]) begin
                    ram[idx][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_err   = err_q;

`ifdef DMEM_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;
    logic [31:0] stat_err_q, stat_err_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        stat_rd_d  = stat_rd_q;
        stat_wr_d  = stat_wr_q;
        stat_err_d = stat_err_q;
        if (capture) begin
            if (req_err) begin
                stat_err_d = sat_inc(stat_err_q);
            end else if (mem_we) begin
                stat_wr_d = sat_inc(stat_wr_q);
            end else begin
                stat_rd_d = sat_inc(stat_rd_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd_q  <= '0;
            stat_wr_q  <= '0;
            stat_err_q <= '0;
        end else begin
            stat_rd_q  <= stat_rd_d;
            stat_wr_q  <= stat_wr_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`else
    assign stat_rd  = '0;
    assign stat_wr  = '0;
    assign stat_err = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder.
module tb_dmem_responder;
    logic        clk;
    logic        rst_n;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic        mem_req;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic [31:0] stat_rd;
    logic [31:0] stat_wr;
    logic [31:0] stat_err;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_req   (mem_req),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .stat_rd   (stat_rd),
        .stat_wr   (stat_wr),
        .stat_err  (stat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One access with req held for hold cycles; later-cycle addr/wdata are scrambled.
    // resp_* is the response cycle, rest_* ORs every following cycle up to req low.
    task automatic access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] resp_rd, output logic resp_err,
                          output logic [31:0] rest_rd, output logic rest_err);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_be = be; mem_wdata = wdata;
        @(posedge clk); #1;
        resp_rd = mem_rdata; resp_err = mem_err;
        rest_rd = '0; rest_err = 1'b0;
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            mem_addr = addr ^ 32'h40; mem_wdata = ~wdata;
            @(posedge clk); #1;
            rest_rd |= mem_rdata; rest_err |= mem_err;
        end
        @(negedge clk);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rest_rd |= mem_rdata; rest_err |= mem_err;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; mem_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_checks++;
        if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_out: rdata=%h err=%b required 0/0", mem_rdata, mem_err);
        end
        n_checks++;
        if (stat_rd !== 0 || stat_wr !== 0 || stat_err !== 0) begin
            n_fail++; $display("FAIL reset_stats: %0d/%0d/%0d required 0/0/0", stat_rd, stat_wr, stat_err);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] rd, rr; logic e, re;
        access(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b0 || rr !== 32'h0 || re !== 1'b0) begin
            n_fail++; $display("FAIL wr_resp: rdata=%h err=%b rest=%h/%b required all 0", rd, e, rr, re);
        end
        access(1'b0, 32'h10, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'hDEADBEEF || e !== 1'b0) begin
            n_fail++; $display("FAIL rd_resp: rdata=%h err=%b required deadbeef/0", rd, e);
        end
        n_checks++;
        if (rr !== 32'h0 || re !== 1'b0) begin
            n_fail++; $display("FAIL rd_after: rdata=%h err=%b required 0/0", rr, re);
        end
    endtask

    task automatic test_byte_lane();
        logic [31:0] rd, rr; logic e, re;
        access(1'b1, 32'h20, 4'hF, 32'h11223344, 2, rd, e, rr, re);
        access(1'b1, 32'h20, 4'b0100, 32'h00AA0000, 2, rd, e, rr, re);
        access(1'b0, 32'h20, 4'h0, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h11AA3344 || e !== 1'b0) begin
            n_fail++; $display("FAIL byte_lane: rdata=%h err=%b required 11aa3344/0", rd, e);
        end
        access(1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 2, rd, e, rr, re);
        n_checks++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL be_zero_err: err=%b required 0", e);
        end
        access(1'b0, 32'h20, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h11AA3344) begin
            n_fail++; $display("FAIL be_zero_keep: rdata=%h required 11aa3344", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, rr; logic e, re;
        access(1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, 2, rd, e, rr, re);
        access(1'b0, 32'h1000, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b1 || re !== 1'b0) begin
            n_fail++; $display("FAIL rd_oob: rdata=%h err=%b after=%b required 0/1/0", rd, e, re);
        end
        access(1'b1, 32'h1000, 4'hF, 32'h12345678, 2, rd, e, rr, re);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL wr_oob_err: err=%b required 1", e);
        end
        access(1'b0, 32'h0, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'hA5A5A5A5 || e !== 1'b0) begin
            n_fail++; $display("FAIL wr_oob_nochange: rdata=%h err=%b required a5a5a5a5/0", rd, e);
        end
        access(1'b0, 32'h6, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h0 || e !== 1'b1) begin
            n_fail++; $display("FAIL rd_misalign: rdata=%h err=%b required 0/1", rd, e);
        end
        access(1'b0, 32'hFFFFFFFC, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL rd_top_addr: err=%b required 1", e);
        end
        access(1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, 2, rd, e, rr, re);
        access(1'b0, 32'hFFC, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'hCAFEF00D || e !== 1'b0) begin
            n_fail++; $display("FAIL last_word: rdata=%h err=%b required cafef00d/0", rd, e);
        end
    endtask

    task automatic test_held_req();
        logic [31:0] rd, rr; logic e, re;
        access(1'b1, 32'h30, 4'hF, 32'h55, 5, rd, e, rr, re);
        access(1'b0, 32'h30, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h55) begin
            n_fail++; $display("FAIL held_wr_once: rdata=%h required 00000055", rd);
        end
        access(1'b0, 32'h70, 4'hF, 32'h0, 2, rd, e, rr, re);
        access(1'b1, 32'h70, 4'hF, 32'h0BADF00D, 2, rd, e, rr, re);
        access(1'b0, 32'h20, 4'hF, 32'h0, 5, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h11AA3344 || e !== 1'b0) begin
            n_fail++; $display("FAIL held_rd_resp: rdata=%h err=%b required 11aa3344/0", rd, e);
        end
        n_checks++;
        if (rr !== 32'h0 || re !== 1'b0) begin
            n_fail++; $display("FAIL held_rd_pulse: rest=%h/%b required 0/0", rr, re);
        end
        // Response above arrives one cycle after a single req-low cycle, so the FSM was back in IDLE.
        access(1'b0, 32'h70, 4'hF, 32'h0, 1, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h0BADF00D || rr !== 32'h0) begin
            n_fail++; $display("FAIL abort_rd: rdata=%h after=%h required 0badf00d/0", rd, rr);
        end
        access(1'b0, 32'h10, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL after_abort: rdata=%h required deadbeef", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, rr; logic e, re;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h10; mem_be = 4'hF;
        @(posedge clk); #1;
        n_checks++;
        if (mem_rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL mid_pre: rdata=%h required deadbeef", mem_rdata);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_rdata !== 32'h0 || mem_err !== 1'b0) begin
            n_fail++; $display("FAIL mid_async_clr: rdata=%h err=%b required 0/0", mem_rdata, mem_err);
        end
        mem_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 32'h30, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (rd !== 32'h55 || e !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_rd: rdata=%h err=%b required 00000055/0", rd, e);
        end
    endtask

    task automatic test_stats();
        logic [31:0] rd, rr; logic e, re;
        logic [31:0] exp_rd, exp_wr, exp_err;
`ifdef DMEM_STATS_EN
        exp_rd = 32'd3; exp_wr = 32'd2; exp_err = 32'd1;
`else
        exp_rd = 32'd0; exp_wr = 32'd0; exp_err = 32'd0;
`endif
        do_reset();
        access(1'b0, 32'h10, 4'hF, 32'h0, 2, rd, e, rr, re);
        access(1'b0, 32'h20, 4'hF, 32'h0, 5, rd, e, rr, re);
        access(1'b0, 32'h30, 4'hF, 32'h0, 2, rd, e, rr, re);
        access(1'b1, 32'h40, 4'hF, 32'h1, 2, rd, e, rr, re);
        access(1'b1, 32'h44, 4'hF, 32'h2, 5, rd, e, rr, re);
        access(1'b0, 32'h2000, 4'hF, 32'h0, 2, rd, e, rr, re);
        n_checks++;
        if (stat_rd !== exp_rd || stat_wr !== exp_wr || stat_err !== exp_err) begin
            n_fail++;
            $display("FAIL stats: rd/wr/err=%0d/%0d/%0d required %0d/%0d/%0d",
                     stat_rd, stat_wr, stat_err, exp_rd, exp_wr, exp_err);
        end
    endtask

    initial begin
        rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_be = '0; mem_wdata = '0;
        test_reset();
        test_write_read();
        test_byte_lane();
        test_errors();
        test_held_req();
        test_reset_mid();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
